bus_share_arb: RTL and testbench
================================

# bus_share_arb

Two-requester, round-robin arbiter that shares one WIDTH-bit datapath port between requester A and requester B. It drives the select input of the 16-bit 2:1 datapath mux (mux16b2: S=0 passes A, S=1 passes B) and registers the selected word toward the shared resource. It uses per-requester REQ/GNT handshakes and downstream back-pressure via RDY. Bursts are capped at MAX_BURST words so neither requester can starve the other. The block sits between the two datapath sources (e.g. ALU result and memory read-back) and the single write port they contend for.

## Interface
- WIDTH, 16, data width of both sources and of O
- MAX_BURST, 4, maximum consecutive accepted words per grant while the other side is requesting; legal range 1..255
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- REQ_A  in  1  requester A has a valid word on DATA_A
- DATA_A  in  WIDTH  requester A word
- REQ_B  in  1  requester B has a valid word on DATA_B
- DATA_B  in  WIDTH  requester B word
- RDY  in  1  shared resource can accept a word this cycle
- GNT_A  out  1  A owns the port (registered)
- GNT_B  out  1  B owns the port (registered)
- SEL  out  1  mux select, equals GNT_B (0 = A, 1 = B)
- O  out  WIDTH  registered accepted word
- O_VALID  out  1  one-cycle pulse, O holds a newly accepted word

## Operation
- States: IDLE, OWN_A, OWN_B. GNT_A=1 only in OWN_A, GNT_B=1 only in OWN_B, never both.
- LAST pointer records the last owner; reset value B, so A wins the first contested arbitration.
- Transfer: a word is accepted on a rising edge where GNT_x=1, REQ_x=1 and RDY=1. On acceptance, O <= DATA_x, O_VALID <= 1, and CNT <= CNT+1. Otherwise O_VALID <= 0 and O holds its value.
- IDLE transitions:
  - Neither REQ asserted: stay in IDLE.
  - Only one REQ asserted: go to that owner.
  - Both REQ asserted: go to the side that is not LAST.
  - CNT <= 0 on entry to any state.
- OWN_x transitions, evaluated each cycle on current inputs:
  - REQ_x=0: go to OWN_other if REQ_other=1, else IDLE. LAST <= x.
  - Word accepted with CNT+1 = MAX_BURST and REQ_other=1: go to OWN_other. LAST <= x, CNT <= 0.
  - Word accepted with CNT+1 = MAX_BURST and REQ_other=0: stay in OWN_x with CNT <= 0 (no forced idle).
  - Otherwise: stay in OWN_x.
- RDY=0 stalls the transfer. The grant, CNT and DATA selection are all held. The burst cap counts accepted words only.
- A requester must hold DATA_x stable while REQ_x=1 and no acceptance has occurred. The arbiter does not buffer unaccepted words.
- CNT width is 8 bits. CNT never exceeds MAX_BURST-1 between edges.

## Timing
- Reset values: state IDLE, GNT_A=0, GNT_B=0, SEL=0, O=0, O_VALID=0, CNT=0, LAST=B.
- RST asserted mid-burst takes effect at the next edge, overriding any acceptance on that edge. O_VALID is 0 the cycle after.
- Grant latency: REQ_x rises in cycle n while IDLE → GNT_x=1 in cycle n+1.
- First word: with RDY=1, the first acceptance is at the end of cycle n+1, O_VALID=1 in cycle n+2.
- Steady-state throughput: one word per cycle while RDY=1 within a burst.
- Handover: the last A word is accepted at the end of cycle m (cap reached, REQ_B=1). Then GNT_B=1 in m+1 and the first B word is accepted at the end of m+1. There is no dead cycle.
- Requester drop: REQ_x falls in cycle m → GNT_x=0 in m+1. No word from x is accepted in cycle m.
- SEL changes on the same edge as GNT, so the mux output settles within the owning cycle.

## Test plan
- Reset, then REQ_A=1, DATA_A='hAAAA, RDY=1 → GNT_A=1 one cycle later, O='hAAAA with O_VALID=1 the cycle after, SEL=0.
- Both REQ rise together from reset, DATA_A='h0000, DATA_B='hFFFF, RDY=1, MAX_BURST=4 → four 'h0000 words, then SEL=1 and four 'hFFFF words, alternating with no dead cycles.
- OWN_B, RDY=0 for 3 cycles with REQ_A=1 → GNT_B held, O_VALID=0, CNT unchanged. B resumes when RDY=1.
- Only REQ_B=1, DATA_B='hB0B0, 10 cycles → GNT_B never drops, ten O_VALID pulses each with O='hB0B0.
- OWN_A, drop REQ_A while REQ_B=1 → GNT_A=0 and GNT_B=1 next cycle. LAST=A, so a later contested IDLE grants B.
- Assert RST mid-burst with RDY=1 → next cycle all outputs at reset values. The next contested request grants A.

Source files
------------

// File: rtl/bus_share_arb.sv
// Round-robin arbiter that shares one WIDTH-bit write port between requesters A and B.
// Grant is one cycle after request; the accepted word is registered, so O_VALID comes one cycle after acceptance.
// Back-pressure: RDY=0 holds the grant, the burst count and the data selection.
module bus_share_arb #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_A,
    input  logic [WIDTH-1:0] DATA_A,
    input  logic             REQ_B,
    input  logic [WIDTH-1:0] DATA_B,
    input  logic             RDY,
    output logic             GNT_A,
    output logic             GNT_B,
    output logic             SEL,
    output logic [WIDTH-1:0] O,
    output logic             O_VALID
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic       LAST_A = 1'b0;
    localparam logic       LAST_B = 1'b1;
    localparam logic [7:0] CAP    = 8'(MAX_BURST);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       cnt_inc;
    logic             gnt_a_q, gnt_a_d;
    logic             gnt_b_q, gnt_b_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             o_valid_q, o_valid_d;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        o_d       = o_q;
        o_valid_d = 1'b0;
        cnt_inc   = cnt_q + 8'd1;

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (REQ_A && REQ_B) begin
                    state_d = (last_q == LAST_B) ? OWN_A : OWN_B;
                end else if (REQ_A) begin
                    state_d = OWN_A;
                end else if (REQ_B) begin
                    state_d = OWN_B;
                end
            end

            OWN_A: begin
                if (!REQ_A) begin
                    last_d  = LAST_A;
                    cnt_d   = 8'd0;
                    state_d = REQ_B ? OWN_B : IDLE;
                end else if (RDY) begin
                    o_d       = DATA_A;
                    o_valid_d = 1'b1;
                    if (cnt_inc == CAP) begin
                        // Cap reached: hand over only if B is waiting, else start a fresh burst.
                        cnt_d = 8'd0;
                        if (REQ_B) begin
                            state_d = OWN_B;
                            last_d  = LAST_A;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            OWN_B: begin
                if (!REQ_B) begin
                    last_d  = LAST_B;
                    cnt_d   = 8'd0;
                    state_d = REQ_A ? OWN_A : IDLE;
                end else if (RDY) begin
                    o_d       = DATA_B;
                    o_valid_d = 1'b1;
                    if (cnt_inc == CAP) begin
                        cnt_d = 8'd0;
                        if (REQ_A) begin
                            state_d = OWN_A;
                            last_d  = LAST_B;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        gnt_a_d = (state_d == OWN_A);
        gnt_b_d = (state_d == OWN_B);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            last_q    <= LAST_B;
            cnt_q     <= 8'd0;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign GNT_A   = gnt_a_q;
    assign GNT_B   = gnt_b_q;
    assign SEL     = gnt_b_q;
    assign O       = o_q;
    assign O_VALID = o_valid_q;

endmodule

// File: tb/tb_bus_share_arb.sv
// Randomized bench for bus_share_arb against an owner/burst-count reference model.
module tb_bus_share_arb;

    localparam int MB = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_A = 1'b0, REQ_B = 1'b0, RDY = 1'b0;
    logic [15:0] DATA_A = 16'h0, DATA_B = 16'h0;
    logic        GNT_A, GNT_B, SEL, O_VALID;
    logic [15:0] O;

    bus_share_arb #(.WIDTH(16), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_A(REQ_A), .DATA_A(DATA_A),
        .REQ_B(REQ_B), .DATA_B(DATA_B),
        .RDY(RDY),
        .GNT_A(GNT_A), .GNT_B(GNT_B), .SEL(SEL),
        .O(O), .O_VALID(O_VALID)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_bad = 0;

    // Reference: owner 0=none, 1=A, 2=B; words taken in the current grant; last owner.
    int          m_own  = 0;
    int          m_cnt  = 0;
    int          m_last = 2;
    logic [15:0] m_o    = 16'h0;
    logic        m_v    = 1'b0;
    logic        acc_a  = 1'b0;
    logic        acc_b  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int mine, other, oth;
        acc_a = 1'b0;
        acc_b = 1'b0;
        if (RST) begin
            m_own = 0; m_cnt = 0; m_last = 2; m_o = 16'h0; m_v = 1'b0;
            return;
        end
        m_v = 1'b0;
        if (m_own == 0) begin
            if (REQ_A && REQ_B) m_own = (m_last == 1) ? 2 : 1;
            else if (REQ_A)     m_own = 1;
            else if (REQ_B)     m_own = 2;
            m_cnt = 0;
        end else begin
            mine  = (m_own == 1) ? int'(REQ_A) : int'(REQ_B);
            other = (m_own == 1) ? int'(REQ_B) : int'(REQ_A);
            oth   = 3 - m_own;
            if (mine == 0) begin
                m_last = m_own;
                m_own  = (other != 0) ? oth : 0;
                m_cnt  = 0;
            end else if (RDY) begin
                m_o = (m_own == 1) ? DATA_A : DATA_B;
                m_v = 1'b1;
                if (m_own == 1) acc_a = 1'b1; else acc_b = 1'b1;
                m_cnt++;
                if (m_cnt == MB) begin
                    m_cnt = 0;
                    if (other != 0) begin
                        m_last = m_own;
                        m_own  = oth;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        chk("gnt_a",   32'(GNT_A),   32'(m_own == 1));
        chk("gnt_b",   32'(GNT_B),   32'(m_own == 2));
        chk("sel",     32'(SEL),     32'(m_own == 2));
        chk("o_valid", 32'(O_VALID), 32'(m_v));
        chk("o",       32'(O),       32'(m_o));
    endtask

    initial begin
        // Reset
        RST = 1'b1;
        repeat (3) step();
        chk("rst_gnt_a", 32'(GNT_A), 32'd0);
        chk("rst_o",     32'(O),     32'd0);
        RST = 1'b0;

        // Single requester A: grant next cycle, word one cycle later
        REQ_A = 1'b1; DATA_A = 16'hAAAA; RDY = 1'b1;
        step();
        chk("first_gnt_a", 32'(GNT_A), 32'd1);
        step();
        chk("first_word", 32'(O), 32'hAAAA);
        chk("first_vld",  32'(O_VALID), 32'd1);
        REQ_A = 1'b0;
        repeat (2) step();

        // Contested from reset: A wins first, alternates in bursts of MB
        RST = 1'b1; step(); RST = 1'b0;
        REQ_A = 1'b1; REQ_B = 1'b1; DATA_A = 16'h0000; DATA_B = 16'hFFFF; RDY = 1'b1;
        step();
        chk("contest_a_first", 32'(GNT_A), 32'd1);
        for (int i = 0; i < 3 * MB; i++) begin
            step();
            chk("contest_word", 32'(O), (i / MB) % 2 == 0 ? 32'h0000 : 32'hFFFF);
        end

        // Stall under ownership, then resume
        RDY = 1'b0;
        repeat (3) step();
        RDY = 1'b1;
        repeat (3) step();

        // Reset mid-burst, next contested request grants A
        RST = 1'b1; step();
        chk("midrst_vld", 32'(O_VALID), 32'd0);
        RST = 1'b0; step();
        chk("midrst_regrant_a", 32'(GNT_A), 32'd1);

        // Randomized traffic honouring hold-while-unaccepted
        for (int c = 0; c < 3000; c++) begin
            RST = ($urandom_range(0, 199) == 0);
            RDY = ($urandom_range(0, 3) != 0);
            if (REQ_A && !acc_a) begin
                if ($urandom_range(0, 15) == 0) REQ_A = 1'b0;
            end else begin
                REQ_A  = ($urandom_range(0, 3) != 0);
                DATA_A = 16'($urandom);
            end
            if (REQ_B && !acc_b) begin
                if ($urandom_range(0, 15) == 0) REQ_B = 1'b0;
            end else begin
                REQ_B  = ($urandom_range(0, 2) != 0);
                DATA_B = 16'($urandom);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
